alu_seq_ctrl: RTL and testbench

- Hardwired control unit that sequences the datapath through fetch (T0–T2) and execute (T3–T6) for register-format ALU, mul/div, neg/not, nop and halt instructions.
- Drives the datapath's bus-source selects, register-load enables, ALU operation code and memory read strobe.
- Decodes the IR value returned by the datapath.
- Replaces the hand-stepped testbench sequencing used during bring-up.

---
 rtl/alu_seq_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: hardwired control unit for the register-format datapath.
// Sequences fetch (T0-T2) and execute (T3-T6) for R-type ALU, mul/div,
// neg/not, nop and halt. Drives bus-source selects, load enables, the ALU
// op code and the memory read strobe from the registered state and IR.
// Optional retired-instruction counter: define ALU_SEQ_INSTR_COUNT_EN.
module alu_seq_ctrl #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned OPW   = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             mem_rdy,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             ZHIout,
    output logic             ZLOout,
    output logic             HIout,
    output logic             LOout,
    output logic             MDRout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             HIin,
    output logic             LOin,
    output logic             ZHIin,
    output logic             ZLOin,
    output logic             IncPC,
    output logic             Read,
    output logic [OPW-1:0]   operation,
    output logic [NREGS-1:0] enableReg,
    output logic [NREGS-1:0] Rout,
    output logic             halted,
    output logic             illegal,
    output logic             busy
`ifdef ALU_SEQ_INSTR_COUNT_EN
    ,
    output logic [31:0]      instr_count
`endif
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu, ClsMulDiv, ClsNegNot, ClsNop, ClsHalt, ClsIllegal
    } op_class_e;

    state_e      state_q, state_d;
    logic        t1_wait_q;  // T1 already lasted a cycle: PCin must not repeat
    op_class_e   op_class;
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic [14:0] unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ir[14:0];

    function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Classify the opcode currently held in IR
    always_comb begin
        op_class = ClsIllegal;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: op_class = ClsAlu;
            5'b01111, 5'b10000:                     op_class = ClsMulDiv;
            5'b10001, 5'b10010:                     op_class = ClsNegNot;
            5'b11010:                               op_class = ClsNop;
            5'b11011:                               op_class = ClsHalt;
            default:                                op_class = ClsIllegal;
        endcase
    end

    // State register plus the first-T1-cycle tracker
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StIdle;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= (state_q == StT1);
        end
    end

    // Next state and decoded datapath controls
    always_comb begin
        state_d   = state_q;
        PCout     = 1'b0;
        ZHIout    = 1'b0;
        ZLOout    = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        ZHIin     = 1'b0;
        ZLOin     = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        operation = '0;
        enableReg = '0;
        Rout      = '0;
        halted    = 1'b0;
        illegal   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StT0;
            end
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZLOin   = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                ZLOout = 1'b1;
                PCin   = ~t1_wait_q;
                Read   = 1'b1;
                MDRin  = 1'b1;
                if (mem_rdy) state_d = StT2;
            end
            StT2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                case (op_class)
                    ClsAlu, ClsNegNot: begin
                        Rout    = reg_sel(rb);
                        Yin     = 1'b1;
                        state_d = StT4;
                    end
                    ClsMulDiv: begin
                        Rout    = reg_sel(ra);
                        Yin     = 1'b1;
                        state_d = StT4;
                    end
                    ClsNop:  state_d = run ? StT0 : StIdle;
                    ClsHalt: state_d = StHalt;
                    default: begin
                        illegal = 1'b1;
                        state_d = run ? StT0 : StIdle;
                    end
                endcase
            end
            StT4: begin
                operation = OPW'(opcode);
                ZLOin     = 1'b1;
                case (op_class)
                    ClsMulDiv: begin
                        Rout  = reg_sel(rb);
                        ZHIin = 1'b1;
                    end
                    ClsNegNot: Rout = reg_sel(rb);
                    default:   Rout = reg_sel(rc);
                endcase
                state_d = StT5;
            end
            StT5: begin
                ZLOout = 1'b1;
                if (op_class == ClsMulDiv) begin
                    LOin    = 1'b1;
                    state_d = StT6;
                end else begin
                    enableReg = reg_sel(ra);
                    state_d   = run ? StT0 : StIdle;
                end
            end
            StT6: begin
                ZHIout  = 1'b1;
                HIin    = 1'b1;
                state_d = run ? StT0 : StIdle;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        busy = (state_q != StIdle) && (state_q != StHalt);
    end

`ifdef ALU_SEQ_INSTR_COUNT_EN
    logic        instr_done;
    logic [31:0] instr_count_q;

    // An instruction retires whenever an active state hands back to T0/IDLE
    always_comb begin
        instr_done = busy && ((state_d == StT0) || (state_d == StIdle));
    end

    // Retired-instruction counter, wraps at 2^32
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            instr_count_q <= '0;
        end else if (instr_done) begin
            instr_count_q <= instr_count_q + 32'd1;
        end
    end

    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed instruction table, hand-written corner
// sequences (T1 stall, illegal, reset in T4, halt) and randomized programs
// checked cycle by cycle against a per-instruction expected-trace model.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

    typedef struct packed {
        logic pc_out, zhi_out, zlo_out, hi_out, lo_out, mdr_out;
        logic mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhi_in, zlo_in;
        logic inc_pc, read, halted, illegal, busy;
        logic [4:0]  oper;
        logic [15:0] en;
        logic [15:0] rout;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    in_t1;
        bit    rdy;
    } step_t;

    typedef struct {
        logic [31:0] ir;
        int          lat;
        logic [15:0] t3_rout;
        logic [15:0] t4_rout;
        logic [4:0]  t4_op;
        logic [15:0] wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr, run, mem_rdy;
    logic [31:0] ir;
    logic PCout, ZHIout, ZLOout, HIout, LOout, MDRout, MARin, PCin, MDRin, IRin;
    logic Yin, HIin, LOin, ZHIin, ZLOin, IncPC, Read, halted, illegal, busy;
    logic [4:0]  operation;
    logic [15:0] enableReg, Rout;
`ifdef ALU_SEQ_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    outs_t act;
    assign act = {PCout, ZHIout, ZLOout, HIout, LOout, MDRout, MARin, PCin, MDRin, IRin,
                  Yin, HIin, LOin, ZHIin, ZLOin, IncPC, Read, halted, illegal, busy,
                  operation, enableReg, Rout};

    alu_seq_ctrl #(.NREGS(16), .OPW(5)) dut (
        .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
        .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout), .HIout(HIout), .LOout(LOout),
        .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin),
        .IncPC(IncPC), .Read(Read), .operation(operation), .enableReg(enableReg),
        .Rout(Rout), .halted(halted), .illegal(illegal), .busy(busy)
`ifdef ALU_SEQ_INSTR_COUNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    step_t exp_q[$];
    int n_read, n_pcin, n_irin, n_ill;
    logic [15:0] or_en;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'h1 << i;
    endfunction

    // Expected per-cycle controls for one instruction, starting at its T0
    task automatic build(input logic [31:0] i, input int stalls);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit alu, md, nn;
        outs_t o;
        step_t s;
        op  = i[31:27];
        ra  = i[26:23];
        rb  = i[22:19];
        rc  = i[18:15];
        alu = (op >= 5'd3) && (op <= 5'd11);
        md  = (op == 5'd15) || (op == 5'd16);
        nn  = (op == 5'd17) || (op == 5'd18);
        exp_q.delete();
        o = '0; o.busy = 1; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.zlo_in = 1;
        s.o = o; s.in_t1 = 0; s.rdy = 0; exp_q.push_back(s);
        for (int k = 0; k <= stalls; k++) begin
            o = '0; o.busy = 1; o.zlo_out = 1; o.read = 1; o.mdr_in = 1; o.pc_in = (k == 0);
            s.o = o; s.in_t1 = 1; s.rdy = (k == stalls); exp_q.push_back(s);
        end
        o = '0; o.busy = 1; o.mdr_out = 1; o.ir_in = 1;
        s.o = o; s.in_t1 = 0; exp_q.push_back(s);
        o = '0; o.busy = 1;
        if (alu || nn) begin o.rout = oh(rb); o.y_in = 1; end
        else if (md) begin o.rout = oh(ra); o.y_in = 1; end
        else if (op != 5'd26 && op != 5'd27) o.illegal = 1;
        s.o = o; exp_q.push_back(s);
        if (!(alu || md || nn)) return;
        o = '0; o.busy = 1; o.oper = op; o.zlo_in = 1; o.zhi_in = md;
        o.rout = (md || nn) ? oh(rb) : oh(rc);
        s.o = o; exp_q.push_back(s);
        o = '0; o.busy = 1; o.zlo_out = 1;
        if (md) o.lo_in = 1; else o.en = oh(ra);
        s.o = o; exp_q.push_back(s);
        if (md) begin
            o = '0; o.busy = 1; o.zhi_out = 1; o.hi_in = 1;
            s.o = o; exp_q.push_back(s);
        end
    endtask

    // Drive one instruction from its T0 (at posedge+1), checking every cycle
    task automatic run_instr(input logic [31:0] i, input int stalls, input bit run_end,
                             input int ncyc);
        int n;
        build(i, stalls);
        n = (ncyc >= 0 && ncyc < exp_q.size()) ? ncyc : exp_q.size();
        n_read = 0; n_pcin = 0; n_irin = 0; n_ill = 0; or_en = '0;
        for (int k = 0; k < n; k++) begin
            ir      = i;
            mem_rdy = exp_q[k].in_t1 ? exp_q[k].rdy : 1'($urandom_range(0, 1));
            run     = (k == exp_q.size() - 1) ? run_end : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("instr_%08h_cyc%0d", i, k), 64'(act), 64'(exp_q[k].o));
            n_read += int'(Read);
            n_pcin += int'(PCin);
            n_irin += int'(IRin);
            n_ill  += int'(illegal);
            or_en  |= enableReg;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            run     = (j == n - 1);
            mem_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_zero", 64'(act), 64'h0);
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl[8];
    logic [4:0] valid_ops[14];

    initial begin
        outs_t hv;
        hv = '0; hv.halted = 1;
        tbl[0] = '{32'h28918000, 6, 16'h0004, 16'h0008, 5'h05, 16'h0002};
        tbl[1] = '{32'h80918000, 7, 16'h0002, 16'h0004, 5'h10, 16'h0000};
        tbl[2] = '{32'h78780000, 7, 16'h0001, 16'h8000, 5'h0F, 16'h0000};
        tbl[3] = '{32'h88280000, 6, 16'h0020, 16'h0020, 5'h11, 16'h0001};
        tbl[4] = '{32'h1F838000, 6, 16'h0001, 16'h0080, 5'h03, 16'h8000};
        tbl[5] = '{32'h59A28000, 6, 16'h0010, 16'h0020, 5'h0B, 16'h0008};
        tbl[6] = '{32'h91480000, 6, 16'h0200, 16'h0200, 5'h12, 16'h0004};
        tbl[7] = '{32'hD0000000, 4, 16'h0000, 16'h0000, 5'h00, 16'h0000};
        valid_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                      5'd15, 5'd16, 5'd17, 5'd18, 5'd26};

        // Reset state
        clr = 1'b0; run = 1'b0; mem_rdy = 1'b0; ir = '0;
        #1 chk("reset_outputs", 64'(act), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_held", 64'(act), 64'h0);
        clr = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // Directed table; each vector starts with its T0 already seen
        run = 1'b1; mem_rdy = 1'b1; ir = tbl[0].ir;
        @(posedge clk); #1;
        for (int v = 0; v < 8; v++) begin
            int lat;
            bit seen;
            logic [15:0] t3r, t4r, wr;
            logic [4:0] t4op;
            lat = -1; wr = '0; t3r = '0; t4r = '0; t4op = '0;
            ir = tbl[v].ir; run = 1'b1; mem_rdy = 1'b1;
            for (int c = 1; c < 20; c++) begin
                @(negedge clk);
                if (c == 3) t3r = Rout;
                if (c == 4) begin t4r = Rout; t4op = operation; end
                seen = (PCout === 1'b1);
                if (!seen) wr |= enableReg;
                @(posedge clk); #1;
                if (seen) begin lat = c; break; end
            end
            chk($sformatf("tbl%0d_latency", v), 64'(lat), 64'(tbl[v].lat));
            chk($sformatf("tbl%0d_t3_rout", v), 64'(t3r), 64'(tbl[v].t3_rout));
            chk($sformatf("tbl%0d_t4_rout", v), 64'(t4r), 64'(tbl[v].t4_rout));
            chk($sformatf("tbl%0d_t4_op", v), 64'(t4op), 64'(tbl[v].t4_op));
            chk($sformatf("tbl%0d_writeback", v), 64'(wr), 64'(tbl[v].wr));
        end
        // Now in T1 of a nop; finish it with run low to reach IDLE
        ir = 32'hD0000000; run = 1'b0; mem_rdy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        idle(1);

        // T1 stall of three cycles
        run_instr(32'h28918000, 3, 1'b1, -1);
        chk("stall_read_cycles", 64'(n_read), 64'd4);
        chk("stall_pcin_cycles", 64'(n_pcin), 64'd1);
        chk("stall_irin_cycles", 64'(n_irin), 64'd1);

        // Undefined opcode 11111
        run_instr(32'hF8918000, 0, 1'b1, -1);
        chk("illegal_pulses", 64'(n_ill), 64'd1);
        chk("illegal_no_write", 64'(or_en), 64'h0);

        // Reset asserted in T4 of an add
        run_instr(32'h1F838000, 0, 1'b1, 4);
        ir = 32'h1F838000;
        @(negedge clk);
        chk("add_t4_before_clr", 64'(act), 64'(exp_q[4].o));
        clr = 1'b0;
        #1 chk("clr_async_in_t4", 64'(act), 64'h0);
        @(posedge clk); #1;
        chk("clr_no_writeback", 64'(act), 64'h0);
        clr = 1'b1; run = 1'b1;
        @(negedge clk);
        chk("after_clr_idle", 64'(act), 64'h0);
        @(posedge clk); #1;

        // Randomized instruction stream
        for (int r = 0; r < 200; r++) begin
            logic [4:0] op;
            logic [31:0] i;
            bit re;
            if ($urandom_range(0, 9) < 7) op = valid_ops[$urandom_range(0, 13)];
            else begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'd27) op = 5'd31;
            end
            i  = {op, 27'($urandom)};
            re = ($urandom_range(0, 3) != 0);
            run_instr(i, $urandom_range(0, 3), re, -1);
            if (!re) idle($urandom_range(1, 3));
        end

        // Halt: sticky despite run, left only via reset
        run_instr(32'hD8000000, 0, 1'b1, -1);
        for (int h = 0; h < 4; h++) begin
            run = 1'b1; mem_rdy = 1'b1;
            @(negedge clk);
            chk($sformatf("halt_cyc%0d", h), 64'(act), 64'(hv));
            @(posedge clk); #1;
        end
        clr = 1'b0;
        #1 chk("halt_clr_async", 64'(act), 64'h0);
        @(posedge clk); #1;
        clr = 1'b1;
        idle(1);
        run_instr(32'hD0000000, 0, 1'b0, -1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
